// File: rtl/led_status_ctrl.sv
// led_status_ctrl: multi-channel LED status driver with per-channel pattern,
// PWM brightness and event pulse-stretch, all on a shared time base.
module led_status_ctrl #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned CLK_HZ        = 150000000,
    parameter int unsigned TICK_HZ       = 1000,
    parameter int unsigned PWM_BITS      = 4,
    parameter int unsigned STRETCH_TICKS = 50
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3*N_CH-1:0]            mode_i,
    input  logic [PWM_BITS*N_CH-1:0]     brightness_i,
    input  logic [N_CH-1:0]              event_i,
    output logic [N_CH-1:0]              led_o,
    output logic                         tick_o
);

    localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
    localparam int unsigned PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned STR_W   = $clog2(STRETCH_TICKS + 1);
    localparam int unsigned MS_W    = 10;

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_SLOW    = 3'd2,
        MODE_FAST    = 3'd3,
        MODE_HEART   = 3'd4,
        MODE_STRETCH = 3'd5,
        MODE_ALIVE   = 3'd6,
        MODE_RSVD    = 3'd7
    } mode_e;

    logic [PRESC_W-1:0]          presc_q, presc_d;
    logic                        tick_q, tick_d;
    logic [MS_W-1:0]             ms_q, ms_d;
    logic [PWM_BITS-1:0]         pwm_q, pwm_d;
    logic [N_CH-1:0]             ev_q, ev_d;
    logic [N_CH-1:0][STR_W-1:0]  str_q, str_d;
    logic [N_CH-1:0]             led_q, led_d;
    logic [N_CH-1:0]             rise_c, pat_c, pwm_on_c;

    // Shared time base: prescaler with registered tick, ms counter, PWM ramp.
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        tick_d  = 1'b0;
        if (presc_q == PRESC_W'(DIV - 1)) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end
        ms_d  = tick_q ? (ms_q + MS_W'(1)) : ms_q;
        pwm_d = pwm_q + PWM_BITS'(1);
    end

    // Per-channel edge detect, stretch counter, pattern select and PWM gating.
    always_comb begin
        ev_d     = event_i;
        str_d    = str_q;
        rise_c   = '0;
        pat_c    = '0;
        pwm_on_c = '0;
        led_d    = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            // A fresh edge reloads the counter and wins over a same-cycle tick.
            rise_c[ch] = event_i[ch] & ~ev_q[ch];
            if (rise_c[ch]) begin
                str_d[ch] = STR_W'(STRETCH_TICKS);
            end else if (tick_q && (str_q[ch] != '0)) begin
                str_d[ch] = str_q[ch] - STR_W'(1);
            end

            case (mode_e'(mode_i[3*ch +: 3]))
                MODE_ON:      pat_c[ch] = 1'b1;
                MODE_SLOW:    pat_c[ch] = ms_q[9];
                MODE_FAST:    pat_c[ch] = ms_q[7];
                MODE_HEART:   pat_c[ch] = (ms_q[9:6] == 4'd0) || (ms_q[9:6] == 4'd3);
                MODE_STRETCH: pat_c[ch] = (str_q[ch] != '0);
                MODE_ALIVE:   pat_c[ch] = ms_q[8];
                default:      pat_c[ch] = 1'b0;
            endcase

            // All-ones brightness is full on; otherwise duty = brightness/2^PWM_BITS.
            pwm_on_c[ch] = (brightness_i[PWM_BITS*ch +: PWM_BITS] == {PWM_BITS{1'b1}}) ||
                           (pwm_q < brightness_i[PWM_BITS*ch +: PWM_BITS]);
            led_d[ch] = pat_c[ch] & pwm_on_c[ch];
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            ms_q    <= '0;
            pwm_q   <= '0;
            ev_q    <= '0;
            str_q   <= '0;
            led_q   <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            ms_q    <= ms_d;
            pwm_q   <= pwm_d;
            ev_q    <= ev_d;
            str_q   <= str_d;
            led_q   <= led_d;
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl: scenario tasks checked against a cycle-count based model.
module tb_led_status_ctrl;

    localparam int N_CH     = 4;
    localparam int CLK_HZ   = 1000;
    localparam int TICK_HZ  = 100;
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int PWM_BITS = 4;
    localparam int STR      = 5;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [3*N_CH-1:0]        mode;
    logic [PWM_BITS*N_CH-1:0] bri;
    logic [N_CH-1:0]          ev;
    logic [N_CH-1:0]          led;
    logic                     tick;

    int errors = 0;
    int checks = 0;

    led_status_ctrl #(
        .N_CH(N_CH), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ),
        .PWM_BITS(PWM_BITS), .STRETCH_TICKS(STR)
    ) dut (
        .clk(clk), .reset(reset), .mode_i(mode), .brightness_i(bri),
        .event_i(ev), .led_o(led), .tick_o(tick)
    );

    always #5 clk = ~clk;

    // Reference model: everything derived from n = clock edges since reset release.
    // Tick is high in states n = DIV, 2*DIV, ...; ms = ticks seen before state n.
    longint          n;
    longint          last_rise [N_CH];
    logic [N_CH-1:0] ev_prev;
    logic [N_CH-1:0] exp_led;
    logic            exp_tick;
    longint          m_ms;
    logic            m_so;
    int              m_b;
    logic            m_pon;

    function automatic longint ticks_upto(longint x);
        return (x < 0) ? 0 : x / DIV;
    endfunction

    function automatic logic model_pattern(int m, longint ms, logic str_on);
        case (m)
            1:       return 1'b1;
            2:       return ms >= 512;
            3:       return ((ms / 128) % 2) == 1;
            4:       return ((ms / 64) == 0) || ((ms / 64) == 3);
            5:       return str_on;
            6:       return ((ms / 256) % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    // Model update on each edge, using inputs as seen at that edge.
    always @(posedge clk) begin
        if (reset) begin
            n        = 0;
            ev_prev  = '0;
            exp_led  = '0;
            exp_tick = 1'b0;
            for (int i = 0; i < N_CH; i++) last_rise[i] = -1;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                m_ms  = ticks_upto(n - 1) % 1024;
                m_so  = (last_rise[i] >= 0) &&
                        ((ticks_upto(n - 1) - ticks_upto(last_rise[i] - 1)) < STR);
                m_b   = int'(bri[PWM_BITS*i +: PWM_BITS]);
                m_pon = (m_b == 15) || ((n % 16) < m_b);
                exp_led[i] = model_pattern(int'(mode[3*i +: 3]), m_ms, m_so) & m_pon;
            end
            for (int i = 0; i < N_CH; i++)
                if (ev[i] && !ev_prev[i]) last_rise[i] = n + 1;
            ev_prev  = ev;
            n        = n + 1;
            exp_tick = (n % DIV) == 0;
        end
    end

    task automatic test_reset();
        int first;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            mode = 12'($urandom); bri = 16'($urandom); ev = '0;
            @(negedge clk);
            checks++;
            if (led !== 4'b0000) begin errors++; $display("FAIL reset_led got=%b exp=0000", led); end
            checks++;
            if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
        end
        reset = 1'b0;
        first = 0;
        for (int c = 1; c <= 3*DIV; c++) begin
            @(negedge clk);
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL release_led n=%0d got=%b exp=%b", n, led, exp_led); end
            if (tick === 1'b1) begin first = c; break; end
        end
        checks++;
        if (first != DIV) begin errors++; $display("FAIL first_tick got=%0d exp=%0d", first, DIV); end
        first = 0;
        for (int c = 1; c <= 3*DIV; c++) begin
            @(negedge clk);
            if (tick === 1'b1) begin first = c; break; end
        end
        checks++;
        if (first != DIV) begin errors++; $display("FAIL tick_period got=%0d exp=%0d", first, DIV); end
    endtask

    task automatic test_pwm_duty();
        int bs [3];
        int expd [3];
        int highs;
        bs   = '{15, 8, 0};
        expd = '{16, 8, 0};
        mode = 12'h001;
        for (int k = 0; k < 3; k++) begin
            bri = {12'hfff, 4'(bs[k])};
            @(negedge clk);
            highs = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                checks++;
                if (led !== exp_led) begin errors++; $display("FAIL pwm_led n=%0d got=%b exp=%b", n, led, exp_led); end
                if (led[0] === 1'b1) highs++;
            end
            checks++;
            if (highs != expd[k]) begin errors++; $display("FAIL pwm_duty b=%0d got=%0d exp=%0d", bs[k], highs, expd[k]); end
        end
    endtask

    task automatic test_patterns();
        logic   p1, p2;
        longint last1, last2;
        int     seen1, seen2;
        mode = {3'd4, 3'd3, 3'd2, 3'd6};
        bri  = 16'hffff;
        @(negedge clk);
        p1 = led[1]; p2 = led[2]; seen1 = 0; seen2 = 0; last1 = 0; last2 = 0;
        for (int c = 0; c < 11000; c++) begin
            @(negedge clk);
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL pattern_led n=%0d got=%b exp=%b", n, led, exp_led); end
            checks++;
            if (tick !== exp_tick) begin errors++; $display("FAIL pattern_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
            if (led[1] !== p1) begin
                if (seen1 > 0) begin
                    checks++;
                    if (n - last1 != 5120) begin errors++; $display("FAIL slow_period got=%0d exp=5120", n - last1); end
                end
                seen1++; last1 = n; p1 = led[1];
            end
            if (led[2] !== p2) begin
                if (seen2 > 0) begin
                    checks++;
                    if (n - last2 != 1280) begin errors++; $display("FAIL fast_period got=%0d exp=1280", n - last2); end
                end
                seen2++; last2 = n; p2 = led[2];
            end
        end
    endtask

    task automatic test_stretch();
        int highs;
        int waited;
        mode = 12'h005;
        bri  = 16'h000f;
        ev   = '0;
        repeat (3) @(negedge clk);
        // Single one-cycle event at an arbitrary tick phase.
        ev[0] = 1'b1;
        @(negedge clk);
        ev[0] = 1'b0;
        checks++;
        if (led[0] !== 1'b0) begin errors++; $display("FAIL stretch_lat1 got=%b exp=0", led[0]); end
        highs = 0;
        for (int c = 0; c < 8*DIV; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (led[0] !== 1'b1) begin errors++; $display("FAIL stretch_lat2 got=%b exp=1", led[0]); end
            end
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL stretch_led n=%0d got=%b exp=%b", n, led, exp_led); end
            if (led[0] === 1'b1) highs++;
        end
        checks++;
        if (highs < (STR-1)*DIV + 1 || highs > STR*DIV) begin
            errors++; $display("FAIL stretch_len got=%0d exp=%0d..%0d", highs, (STR-1)*DIV + 1, STR*DIV);
        end
        // Retrigger two ticks into a stretch: reload, no accumulation.
        ev[0] = 1'b1;
        @(negedge clk);
        ev[0] = 1'b0;
        waited = 0;
        for (int c = 0; c < 4*DIV && waited < 2; c++) begin
            @(negedge clk);
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL retrig_led n=%0d got=%b exp=%b", n, led, exp_led); end
            if (tick === 1'b1) waited++;
        end
        checks++;
        if (waited != 2) begin errors++; $display("FAIL retrig_wait got=%0d exp=2", waited); end
        ev[0] = 1'b1;
        @(negedge clk);
        ev[0] = 1'b0;
        for (int c = 0; c < 8*DIV; c++) begin
            @(negedge clk);
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL retrig2_led n=%0d got=%b exp=%b", n, led, exp_led); end
        end
        // Event coincident with tick: full STR*DIV cycles of light.
        waited = 0;
        for (int c = 0; c < 3*DIV; c++) begin
            @(negedge clk);
            if (tick === 1'b1) begin waited = 1; break; end
        end
        checks++;
        if (waited != 1) begin errors++; $display("FAIL coinc_wait got=%0d exp=1", waited); end
        ev[0] = 1'b1;
        @(negedge clk);
        ev[0] = 1'b0;
        highs = 0;
        for (int c = 0; c < 8*DIV; c++) begin
            @(negedge clk);
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL coinc_led n=%0d got=%b exp=%b", n, led, exp_led); end
            if (led[0] === 1'b1) highs++;
        end
        checks++;
        if (highs != STR*DIV) begin errors++; $display("FAIL coinc_len got=%0d exp=%0d", highs, STR*DIV); end
        // Random sparse events on all channels with random brightness.
        mode = {3'd5, 3'd5, 3'd5, 3'd5};
        for (int c = 0; c < 2000; c++) begin
            if (c % 64 == 0) bri = 16'($urandom);
            for (int i = 0; i < N_CH; i++) ev[i] = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL rand_stretch n=%0d got=%b exp=%b", n, led, exp_led); end
        end
        ev = '0;
    endtask

    task automatic test_event_reset();
        mode  = 12'h005;
        bri   = 16'h000f;
        reset = 1'b1;
        ev    = 4'b0001;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 10*DIV; c++) begin
            @(negedge clk);
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL evrst_led n=%0d got=%b exp=%b", n, led, exp_led); end
            if (c == 2) begin
                checks++;
                if (led[0] !== 1'b1) begin errors++; $display("FAIL evrst_start got=%b exp=1", led[0]); end
            end
        end
        checks++;
        if (led[0] !== 1'b0) begin errors++; $display("FAIL evrst_noretrig got=%b exp=0", led[0]); end
        ev = '0;
    endtask

    task automatic test_mode_change();
        int found;
        int first;
        mode  = {3'd0, 3'd0, 3'd2, 3'd0};
        bri   = 16'hffff;
        found = 0;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL mc_led n=%0d got=%b exp=%b", n, led, exp_led); end
            if (led[1] === 1'b1) begin found = 1; break; end
        end
        checks++;
        if (found != 1) begin errors++; $display("FAIL mc_wait_high got=%0d exp=1", found); end
        mode = 12'h000;
        @(negedge clk);
        checks++;
        if (led[1] !== 1'b0) begin errors++; $display("FAIL mc_off got=%b exp=0", led[1]); end
        mode = {3'd0, 3'd0, 3'd2, 3'd0};
        @(negedge clk);
        checks++;
        if (led !== exp_led) begin errors++; $display("FAIL mc_restore n=%0d got=%b exp=%b", n, led, exp_led); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (led !== 4'b0000) begin errors++; $display("FAIL mc_reset_led got=%b exp=0000", led); end
        @(negedge clk);
        reset = 1'b0;
        first = 0;
        for (int c = 1; c <= 3*DIV; c++) begin
            @(negedge clk);
            checks++;
            if (led[1] !== 1'b0) begin errors++; $display("FAIL mc_post_led n=%0d got=%b exp=0", n, led[1]); end
            if (tick === 1'b1) begin first = c; break; end
        end
        checks++;
        if (first != DIV) begin errors++; $display("FAIL mc_restart_tick got=%0d exp=%0d", first, DIV); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if (c % 97 == 0) begin mode = 12'($urandom); bri = 16'($urandom); end
            for (int i = 0; i < N_CH; i++) ev[i] = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 499) == 0);
            @(negedge clk);
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL rand_led n=%0d got=%b exp=%b", n, led, exp_led); end
            checks++;
            if (tick !== exp_tick) begin errors++; $display("FAIL rand_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        mode  = '0;
        bri   = '0;
        ev    = '0;
        test_reset();
        test_pwm_duty();
        test_patterns();
        test_stretch();
        test_event_reset();
        test_mode_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
Parametrised multi-channel LED status driver. It replaces the fixed single-LED sign-of-life toggle counter in the board top levels. Each channel has its own selectable pattern: off, on, slow/fast blink, heartbeat, or event pulse-stretch. Each channel also has its own PWM brightness. The block sits in the system clock domain next to the soft-processor subsystem, which drives mode and brightness through PIO registers.

Parameters:
N_CH, 4, number of LED channels
CLK_HZ, 150000000, clk frequency in Hz
TICK_HZ, 1000, pattern time-base rate (1 ms tick); DIV = CLK_HZ/TICK_HZ, must be >= 2
PWM_BITS, 4, brightness resolution per channel
STRETCH_TICKS, 50, event pulse-stretch length in ticks, must be >= 1 and < 2^16

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mode  in  3*N_CH  per-channel mode; channel i uses bits [3i+2:3i]
brightness  in  PWM_BITS*N_CH  per-channel duty; channel i uses bits [PWM_BITS*i +: PWM_BITS]
event  in  N_CH  per-channel event strobe/level, synchronous to clk
led  out  N_CH  registered LED drive, active-high
tick  out  1  one-cycle time-base pulse

Behaviour:
- Reset: all counters cleared; led = 0; tick = 0; event history = 0.
- Because event history resets to 0, an event held high through reset release is treated as a rising edge.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0.
  - tick = 1 for exactly one cycle when count == DIV-1.
  - The first tick occurs DIV cycles after reset deassertion.
- ms_cnt:
  - 10-bit, free-running; increments on tick; wraps 1023 -> 0.
  - Shared by all channels, so channels in the same mode are phase-aligned.
- pwm_cnt: PWM_BITS-bit, increments every clk, wraps.
- pwm_on(i):
  - 1 if brightness(i) == all-ones (100% duty).
  - Otherwise pwm_on(i) = (pwm_cnt < brightness(i)).
  - brightness 0 gives a permanently dark LED.
- Pattern per mode:
  - 0 OFF: 0.
  - 1 ON: 1.
  - 2 SLOW: ms_cnt[9] (1024-tick period, 50%).
  - 3 FAST: ms_cnt[7] (256-tick period).
  - 4 HEARTBEAT: 1 when ms_cnt[9:6] == 0 or ms_cnt[9:6] == 3. This gives two 64-tick flashes per 1024 ticks.
  - 5 STRETCH: 1 while stretch_cnt(i) != 0.
  - 6 ALIVE: ms_cnt[8] (512-tick period). This is the default sign-of-life.
  - 7: reserved, treated as OFF.
- Event stretch, per channel, always running regardless of mode:
  - Edge detect: rise(i) = event(i) & ~event_d(i), where event_d is a 1-cycle delayed copy.
  - On rise, stretch_cnt loads STRETCH_TICKS.
  - Otherwise, on tick with stretch_cnt != 0, it decrements.
  - rise and tick in the same cycle: load wins.
  - A rise while already counting re-triggers: reload, no accumulation.
  - Stretch duration is STRETCH_TICKS-1 to STRETCH_TICKS ticks, depending on tick phase.
- Output: led(i) <= pattern(i) & pwm_on(i), registered. Latency from an input change to led is 1 clk.
  - In mode 5, led rises 2 clk after the event rising edge: one cycle for the edge-detect register, one for the led register.
- Mode or brightness change:
  - Takes effect on the next led update.
  - No counters reset, and no glitch beyond the normal 1-clk latency.
- Reset asserted mid-pattern: led = 0 the cycle after reset is sampled high, and all counters restart from 0.
- Width rules:
  - Prescaler width = clog2(DIV).
  - Stretch counter width = clog2(STRETCH_TICKS+1).
  - All comparisons are unsigned.

Test Plan:
(Sim parameters: CLK_HZ=1000, TICK_HZ=100 giving DIV=10; PWM_BITS=4; STRETCH_TICKS=5; N_CH=4.)
- Reset, then free-run -> tick pulses one cycle at clk 10, 20, 30…; led = 0 throughout reset; ms_cnt wraps after 10240 clk.
- ch0 mode=1 with brightness 15, 8, 0 -> led0 duty 16/16, 8/16, 0/16 measured over 16 clk; brightness 8 gives high for pwm_cnt 0..7.
- ch1 mode=2, ch2 mode=3, ch3 mode=4, all brightness 15 -> led1 toggles every 5120 clk; led2 toggles every 1280 clk; led3 is high for ms_cnt 0-63 and 192-255 and low otherwise.
- ch0 mode=5:
  - Single 1-clk event at clk 3 -> led0 high at clk 5 and low after the 5th subsequent tick.
  - Second event 2 ticks later -> counter reloads to 5 with no accumulation.
  - Event coincident with tick -> counter loads 5 and is not decremented that cycle.
- event0 held high across reset release -> treated as a rising edge, so stretch starts; held high thereafter -> no retrigger.
- Mode change from 2 to 0 mid-blink, then reset pulse during blink -> led off 1 clk after each; ms_cnt and prescaler restart at 0 after reset.
